mod_updown_counter: RTL and testbench
=====================================

# mod_updown_counter

Parametrised synchronous modulo-N up/down counter with enable, parallel load, synchronous clear, selectable wrap or saturate behaviour, and a terminal-count strobe. It is the general-purpose counter for the sequential-circuits library. Typical uses are timers, prescalers, address generators and BCD digit chains, where a chained stage's `en` is driven by the previous stage's `tc`.

## Interface
- `BITS`, default 4: counter width; Q range is 0..MOD-1.
- `MOD`, default 10: modulus. Legal range is 2 ≤ MOD ≤ 2^BITS; the block must fail elaboration outside this range.

- `clk`, input, 1: rising-edge clock; the only clock.
- `reset`, input, 1: synchronous, active-high reset; sampled on `clk` rising edge; highest priority.
- `clear`, input, 1: synchronous clear of Q to 0.
- `load`, input, 1: synchronous parallel load of `d`.
- `d`, input, BITS: load value.
- `en`, input, 1: count enable.
- `up`, input, 1: direction; 1 counts up, 0 counts down.
- `sat`, input, 1: 1 saturates at the terminal value; 0 wraps modulo MOD.
- `Q`, output, BITS: registered count.
- `tc`, output, 1: terminal-count strobe, combinational from Q, `en`, `up`.
- `at_end`, output, 1: Q equals the terminal value for the current direction, regardless of `en`.

## Operation
- Terminal value: MOD-1 when `up`=1; 0 when `up`=0.
- Priority per rising edge, highest first: `reset`, then `clear`, then `load`, then `en`, then hold.
- `reset`=1: Q ← 0.
- `clear`=1: Q ← 0. Identical effect to `reset`; it is a functional control, not a reset.
- `load`=1: Q ← `d` if `d` ≤ MOD-1, otherwise Q ← MOD-1 (clamped). `en`, `up` and `sat` are ignored that cycle.
- `en`=1, `up`=1:
  - Q < MOD-1: Q ← Q+1.
  - Q = MOD-1 and `sat`=0: Q ← 0 (wrap).
  - Q = MOD-1 and `sat`=1: Q holds.
- `en`=1, `up`=0:
  - Q > 0: Q ← Q-1.
  - Q = 0 and `sat`=0: Q ← MOD-1 (wrap).
  - Q = 0 and `sat`=1: Q holds.
- `en`=0 with no higher-priority control: Q holds.
- Arithmetic is done at BITS+1 bits internally and compared against MOD. No out-of-range Q is ever produced, even when MOD = 2^BITS.
- `at_end` = (Q == terminal value).
- `tc` = `en` & `at_end` & ~`clear` & ~`load` & ~`reset`.
  - `tc` is high in exactly the cycle whose edge performs the wrap, or the attempted step while saturated.
  - This makes `tc` directly usable as `en` for a cascaded stage.
- Direction change is legal on any cycle and takes effect on the next edge. `at_end` and `tc` follow `up` combinationally.
- The block contains no internal state other than Q.

## Timing
- Reset value: Q = 0. After reset, `at_end` = 1 if `up`=0, else 0. `tc` = 0 while `reset`=1.
- Latency from `load`/`clear`/`en` to Q: 1 clock (next rising edge).
- `tc` and `at_end` are combinational. Their paths are: Q register to compare, and `en`/`up`/`load`/`clear`/`reset` to output. There is no register stage.
- Reset asserted mid-count: Q = 0 on that edge. Counting resumes on the first edge with `reset`=0 and `en`=1, giving Q = 1 (up) or MOD-1 (down, `sat`=0).
- `load` and `en` asserted together: load wins, with no increment applied to the loaded value.
- `clear` and `load` asserted together: Q ← 0.
- `sat` changed while Q sits at the terminal value: it takes effect on the next edge.

## Test plan
- Reset/default wrap, BITS=4, MOD=10: assert `reset` for 1 cycle, then `en`=1, `up`=1, `sat`=0 for 12 cycles → Q = 0,1,…,9,0,1. `tc` is high only in the cycle where Q=9. `reset` mid-count at Q=6 → Q=0 next edge.
- Down count and wrap, MOD=10: load 2, then `up`=0, `en`=1 → Q = 2,1,0,9,8. `tc` is high when Q=0 only.
- Saturate: `sat`=1, `up`=1 from Q=8 → Q = 8,9,9,9 with `tc` high every cycle at 9. Switch `up`=0 → Q = 8 on the next edge and `tc` drops.
- Priority and clamp: `d`=13 with `load`=1, `en`=1 → Q=9. `clear`+`load` with `d`=5 → Q=0. `en`=0 for 5 cycles → Q holds and `tc`=0.
- Full-range width, BITS=4, MOD=16: count up from 15 → 0. Count down from 0 → 15. No X and no out-of-range value at any point.
- Cascade: two instances with MOD=10, stage 2 `en` driven by stage 1 `tc`. Run 100 cycles → counts 00..99 then back to 00. Stage 2 `tc` is high exactly once, at 99.

Source files
------------

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with enable, load, clear, wrap/saturate
// and a terminal-count strobe for cascading stages.
module mod_updown_counter #(
    parameter int BITS = 4,
    parameter int MOD  = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            load,
    input  logic [BITS-1:0] d,
    input  logic            en,
    input  logic            up,
    input  logic            sat,
    output logic [BITS-1:0] Q,
    output logic            tc,
    output logic            at_end
);

    if (BITS < 1 || BITS > 30 || MOD < 2 || MOD > (2 ** BITS)) begin : g_bad_param
        $error("mod_updown_counter: MOD must satisfy 2 <= MOD <= 2**BITS");
    end

    // Compare at BITS+1 bits so MOD == 2**BITS needs no special case
    localparam logic [BITS:0] LAST = (BITS + 1)'(MOD - 1);

    logic [BITS:0]   q_ext;
    logic [BITS:0]   d_ext;
    logic [BITS:0]   term;
    logic [BITS:0]   q_inc;
    logic [BITS:0]   q_dec;
    logic [BITS-1:0] q_next;

    assign q_ext  = {1'b0, Q};
    assign d_ext  = {1'b0, d};
    assign term   = up ? LAST : '0;
    assign q_inc  = q_ext + 1'b1;
    assign q_dec  = q_ext - 1'b1;
    assign at_end = (q_ext == term);
    assign tc     = en & at_end & ~clear & ~load & ~reset;

    always_comb begin
        q_next = Q;
        if (clear) begin
            q_next = '0;
        end else if (load) begin
            q_next = (d_ext > LAST) ? LAST[BITS-1:0] : d;
        end else if (en) begin
            if (up) begin
                if (!at_end)
                    q_next = q_inc[BITS-1:0];
                else if (!sat)
                    q_next = '0;
            end else begin
                if (!at_end)
                    q_next = q_dec[BITS-1:0];
                else if (!sat)
                    q_next = LAST[BITS-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            Q <= '0;
        else
            Q <= q_next;
    end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter: MOD=10, MOD=16 and a
// two-stage decimal cascade.
module tb_mod_updown_counter;

    logic       clk = 1'b0;
    logic       reset, clear, load, en, up, sat;
    logic [3:0] d;
    logic [3:0] q10, q16;
    logic       tc10, tc16, end10, end16;

    logic       c_reset, c_en;
    logic       c_zero = 1'b0;
    logic       c_one = 1'b1;
    logic [3:0] c_d = 4'd0;
    logic [3:0] c1_q, c2_q;
    logic       c1_tc, c2_tc, c1_end, c2_end;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mod_updown_counter #(.BITS(4), .MOD(10)) u10 (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .d(d),
        .en(en), .up(up), .sat(sat), .Q(q10), .tc(tc10), .at_end(end10)
    );

    mod_updown_counter #(.BITS(4), .MOD(16)) u16 (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .d(d),
        .en(en), .up(up), .sat(sat), .Q(q16), .tc(tc16), .at_end(end16)
    );

    mod_updown_counter #(.BITS(4), .MOD(10)) c1 (
        .clk(clk), .reset(c_reset), .clear(c_zero), .load(c_zero),
        .d(c_d), .en(c_en), .up(c_one), .sat(c_zero), .Q(c1_q),
        .tc(c1_tc), .at_end(c1_end)
    );

    mod_updown_counter #(.BITS(4), .MOD(10)) c2 (
        .clk(clk), .reset(c_reset), .clear(c_zero), .load(c_zero),
        .d(c_d), .en(c1_tc), .up(c_one), .sat(c_zero), .Q(c2_q),
        .tc(c2_tc), .at_end(c2_end)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int dn [5];
        int sa [4];
        int tc2_hits;
        dn = '{2, 1, 0, 9, 8};
        sa = '{8, 9, 9, 9};

        reset = 1; clear = 0; load = 0; en = 0; up = 1; sat = 0; d = 0;
        c_reset = 1; c_en = 0;
        step();
        check("rst_q", 32'(q10), 0);
        check("rst_end_up", 32'(end10), 0);
        en = 1; up = 0; #1;
        check("rst_end_dn", 32'(end10), 1);
        check("rst_tc", 32'(tc10), 0);

        // Wrap count up
        reset = 0; up = 1; en = 1; #1;
        for (int i = 0; i < 12; i++) begin
            check("up_q", 32'(q10), 32'(i % 10));
            check("up_tc", 32'(tc10), 32'((i % 10) == 9));
            step();
        end
        check("up_q12", 32'(q10), 2);
        repeat (4) step();
        check("mid_q6", 32'(q10), 6);
        reset = 1; step();
        check("mid_rst", 32'(q10), 0);
        reset = 0; step();
        check("resume", 32'(q10), 1);

        // Down count with wrap
        load = 1; d = 4'd2; step();
        load = 0; up = 0; #1;
        for (int i = 0; i < 5; i++) begin
            check("dn_q", 32'(q10), 32'(dn[i]));
            check("dn_tc", 32'(tc10), 32'(dn[i] == 0));
            step();
        end

        // Saturate
        load = 1; d = 4'd8; step();
        load = 0; up = 1; sat = 1; #1;
        for (int i = 0; i < 4; i++) begin
            check("sat_q", 32'(q10), 32'(sa[i]));
            check("sat_tc", 32'(tc10), 32'(sa[i] == 9));
            step();
        end
        check("sat_hold", 32'(q10), 9);
        up = 0; #1;
        check("sat_dn_tc", 32'(tc10), 0);
        check("sat_dn_end", 32'(end10), 0);
        step();
        check("sat_dn_q", 32'(q10), 8);

        // Priority and clamp
        load = 1; en = 1; up = 1; d = 4'd13; #1;
        check("ld_tc", 32'(tc10), 0);
        step();
        check("clamp", 32'(q10), 9);
        load = 0; #1;
        check("at9_tc", 32'(tc10), 1);
        clear = 1; #1;
        check("clr_tc", 32'(tc10), 0);
        load = 1; d = 4'd5; step();
        check("clr_ld", 32'(q10), 0);
        clear = 0; load = 0; en = 0; #1;
        for (int i = 0; i < 5; i++) begin
            check("hold_q", 32'(q10), 0);
            check("hold_tc", 32'(tc10), 0);
            step();
        end

        // sat released at the terminal value
        load = 1; d = 4'd9; step();
        load = 0; en = 1; sat = 1; step();
        check("sat9", 32'(q10), 9);
        sat = 0; step();
        check("unsat_wrap", 32'(q10), 0);

        // Full range MOD=16
        en = 0; load = 1; d = 4'd15; step();
        check("m16_ld", 32'(q16), 15);
        load = 0; en = 1; up = 1; sat = 0; #1;
        check("m16_tc_up", 32'(tc16), 1);
        step();
        check("m16_wrap_up", 32'(q16), 0);
        up = 0; #1;
        check("m16_tc_dn", 32'(tc16), 1);
        step();
        check("m16_wrap_dn", 32'(q16), 15);
        up = 1; sat = 1; step();
        check("m16_sat", 32'(q16), 15);
        check("m16_end", 32'(end16), 1);

        // Two-stage decimal cascade
        en = 0;
        c_reset = 0; c_en = 1; #1;
        tc2_hits = 0;
        for (int i = 0; i <= 100; i++) begin
            check("cas_lo", 32'(c1_q), 32'((i % 100) % 10));
            check("cas_hi", 32'(c2_q), 32'((i % 100) / 10));
            check("cas_tc", 32'(c2_tc), 32'((i % 100) == 99));
            if (c2_tc) tc2_hits++;
            step();
        end
        check("cas_tc_once", 32'(tc2_hits), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
